// File: rtl/regfile_pkg.sv
// Shared register-file definitions and round-robin index helpers used by the
// write-port arbiter and its sub-module.
package regfile_pkg;

    localparam int NUM_REGS   = 32;
    localparam int ZERO_REG   = 31;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 64;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dst;
        logic [REG_DATA_W-1:0] data;
    } wr_req_t;

    typedef struct packed {
        logic                  en;
        logic [REG_ADDR_W-1:0] dst;
        logic [REG_DATA_W-1:0] data;
    } wr_port_t;

    // Position k places after base in a ring of n requesters.
    function automatic int rr_index(input int base, input int k, input int n);
        return (base + k) % n;
    endfunction

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first active request found
// when scanning upward from the priority pointer, wrapping at NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o
);
    import regfile_pkg::*;

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'(rr_index(int'(ptr_i), k, NUM_REQ));
            if (en_i && !found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between result producers with
// round-robin grants, a one-cycle registered write stage and a zero-reg filter.
module regfile_write_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = regfile_pkg::REG_DATA_W,
    parameter int ADDR_WIDTH = regfile_pkg::REG_ADDR_W,
    parameter int ZERO_REG   = regfile_pkg::ZERO_REG
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          hold_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_reg_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          wr_en_o,
    output logic [ADDR_WIDTH-1:0]         wr_reg_o,
    output logic [DATA_WIDTH-1:0]         wr_data_o
);
    import regfile_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    gnt;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  arb_en;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] sel_reg;
    logic [DATA_WIDTH-1:0] sel_data;

    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_reg_q, wr_reg_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    // Reset and hold both block grants, so nothing can transfer in either state.
    assign arb_en = !reset_i && !hold_i;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i     (req_valid_i),
        .ptr_i     (ptr_q),
        .en_i      (arb_en),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign req_ready_o = gnt;
    assign xfer        = |gnt;

    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_reg  = req_reg_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A zero-register write is still consumed and advances the pointer, it just never enables the port.
    always_comb begin
        ptr_d     = ptr_q;
        wr_en_d   = 1'b0;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        if (xfer) begin
            ptr_d     = IDX_W'(rr_next(int'(gnt_idx), NUM_REQ));
            wr_en_d   = (sel_reg != ADDR_WIDTH'(ZERO_REG));
            wr_reg_d  = sel_reg;
            wr_data_d = sel_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_reg_o  = wr_reg_q;
    assign wr_data_o = wr_data_q;

endmodule
